kmap_sweep: RTL and testbench

Exhaustive truth-table sweeper that sits directly upstream of the 4-input `kmap` simplifier and also consumes its output. On `start` it drives all 16 input combinations onto A,B,C,D in ascending minterm order and samples the returned `Out` after a programmable settle time. It assembles the measured 16-bit truth table and compares it against a latched golden table. It then reports the per-minterm mismatch count and a pass flag, so LAB2 netlists are self-checked on silicon-like timing rather than by eye.

---
 rtl/kmap_sweep.sv | 113 +++++++++++
 tb/tb_kmap_sweep.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/kmap_sweep.sv
// Exhaustive truth-table sweeper for a 4-input combinational block: drives all 16
// minterms in order, samples the returned output and scores it against a golden table.
module kmap_sweep #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expect_tt,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic [4:0]  err_cnt,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        FIN
    } state_t;

    // With SETTLE==0 the HOLD state is never entered and each vector is sampled immediately.
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam state_t     AFTER_VEC   = (SETTLE > 0) ? HOLD : SAMPLE;

    state_t      state, state_nxt;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;
    logic [15:0] expect_q;
    logic        mismatch;
    logic [4:0]  err_nxt;

    assign mismatch = (f_in != expect_q[idx]);
    assign err_nxt  = err_cnt + {4'd0, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = AFTER_VEC;
            HOLD:    if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (idx == 4'd15) ? FIN : AFTER_VEC;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pass is computed from the count including the final minterm so it lands with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {A, B, C, D} <= 4'd0;
            idx          <= 4'd0;
            settle_cnt   <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tt           <= 16'd0;
            err_cnt      <= 5'd0;
            pass         <= 1'b0;
            expect_q     <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        expect_q     <= expect_tt;
                        tt           <= 16'd0;
                        err_cnt      <= 5'd0;
                        pass         <= 1'b0;
                        idx          <= 4'd0;
                        settle_cnt   <= 4'd0;
                        {A, B, C, D} <= 4'd0;
                        busy         <= 1'b1;
                    end
                end
                HOLD: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    tt[idx] <= f_in;
                    err_cnt <= err_nxt;
                    if (idx == 4'd15) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_nxt == 5'd0);
                    end else begin
                        idx          <= idx + 4'd1;
                        {A, B, C, D} <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kmap_sweep.sv
// Scoreboard bench: three sweepers (SETTLE = 1, 0, 3) each sweep a bench-held truth
// table; expected results come from popcount arithmetic on the tables.
module tb_kmap_sweep;

    typedef struct packed {
        logic [15:0] tt;
        logic [4:0]  err;
        logic        pass;
        logic [31:0] startCyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic [15:0] expect_tt;
    logic [15:0] dev_tt [3];

    logic [3:0]  vec    [3];
    logic        busy_a [3];
    logic        done_a [3];
    logic        pass_a [3];
    logic [15:0] tt_a   [3];
    logic [4:0]  err_a  [3];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t scoreQ [3][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int g,
                               input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s inst%0d: got %0h, expected %0h (cycle %0d)",
                     name, g, actual, required, cyc);
        end
    endtask

    generate
        for (genvar g = 0; g < 3; g++) begin : inst
            localparam int SG = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
            logic        a, b, c, d, f_in, busy, done, pass;
            logic [15:0] tt;
            logic [4:0]  err_cnt;
            logic [3:0]  trace [$];
            logic        holdPending = 1'b0;
            exp_t        last;

            kmap_sweep #(.SETTLE(SG)) dut (
                .clk(clk), .rst_n(rst_n), .start(start[g]), .expect_tt(expect_tt),
                .A(a), .B(b), .C(c), .D(d), .f_in(f_in),
                .busy(busy), .done(done), .tt(tt), .err_cnt(err_cnt), .pass(pass)
            );

            // The device under sweep is just a lookup into the bench's truth table.
            assign f_in      = dev_tt[g][{a, b, c, d}];
            assign vec[g]    = {a, b, c, d};
            assign busy_a[g] = busy;
            assign done_a[g] = done;
            assign pass_a[g] = pass;
            assign tt_a[g]   = tt;
            assign err_a[g]  = err_cnt;

            always @(negedge clk) begin : monitor
                exp_t e;
                int   bad;
                if (!rst_n) begin
                    trace.delete();
                    holdPending = 1'b0;
                end else begin
                    if (holdPending && !busy) begin
                        checkOutput("tt_hold", g, 32'(tt), 32'(last.tt));
                        checkOutput("err_hold", g, 32'(err_cnt), 32'(last.err));
                        checkOutput("pass_hold", g, 32'(pass), 32'(last.pass));
                        checkOutput("abcd_hold", g, 32'({a, b, c, d}), 32'hF);
                    end
                    holdPending = 1'b0;
                    if (busy) trace.push_back({a, b, c, d});
                    if (done) begin
                        if (scoreQ[g].size() == 0) begin
                            checkOutput("unexpected_done", g, 32'(done), 32'd0);
                        end else begin
                            e = scoreQ[g].pop_front();
                            checkOutput("tt", g, 32'(tt), 32'(e.tt));
                            checkOutput("err_cnt", g, 32'(err_cnt), 32'(e.err));
                            checkOutput("pass", g, 32'(pass), 32'(e.pass));
                            checkOutput("done_latency", g, 32'(cyc) - e.startCyc,
                                        32'(16 * (SG + 1)));
                            checkOutput("busy_at_done", g, 32'(busy), 32'd0);
                            checkOutput("abcd_at_done", g, 32'({a, b, c, d}), 32'hF);
                            bad = 0;
                            if (trace.size() != 16 * (SG + 1)) bad++;
                            foreach (trace[i]) begin
                                if (trace[i] != 4'(i / (SG + 1))) bad++;
                            end
                            checkOutput("vector_order_errors", g, 32'(bad), 32'd0);
                            last        = e;
                            holdPending = 1'b1;
                        end
                        trace.delete();
                    end
                end
            end
        end
    endgenerate

    task automatic checkReset();
        for (int g = 0; g < 3; g++) begin
            checkOutput("rst_busy", g, 32'(busy_a[g]), 32'd0);
            checkOutput("rst_done", g, 32'(done_a[g]), 32'd0);
            checkOutput("rst_tt", g, 32'(tt_a[g]), 32'd0);
            checkOutput("rst_err", g, 32'(err_a[g]), 32'd0);
            checkOutput("rst_pass", g, 32'(pass_a[g]), 32'd0);
            checkOutput("rst_abcd", g, 32'(vec[g]), 32'd0);
        end
    endtask

    task automatic waitDone();
        int pending;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (scoreQ[0].size() + scoreQ[1].size() + scoreQ[2].size() == 0) break;
        end
        pending = scoreQ[0].size() + scoreQ[1].size() + scoreQ[2].size();
        checkOutput("sweep_complete_pending", -1, 32'(pending), 32'd0);
        for (int g = 0; g < 3; g++) scoreQ[g].delete();
    endtask

    task automatic issueStart(input logic [15:0] t0, input logic [15:0] t1,
                              input logic [15:0] t2, input logic [15:0] expv);
        exp_t e;
        @(negedge clk);
        dev_tt[0] = t0;
        dev_tt[1] = t1;
        dev_tt[2] = t2;
        expect_tt = expv;
        start     = 3'b111;
        for (int g = 0; g < 3; g++) begin
            e.tt       = dev_tt[g];
            e.err      = 5'($countones(dev_tt[g] ^ expv));
            e.pass     = (e.err == 5'd0);
            e.startCyc = 32'(cyc + 1);
            scoreQ[g].push_back(e);
        end
        @(negedge clk);
        start     = 3'b000;
        expect_tt = 16'($urandom);
    endtask

    // noise re-pulses start and zeroes expect_tt about ten cycles into the sweep.
    task automatic applyStimulus(input logic [15:0] t0, input logic [15:0] t1,
                                 input logic [15:0] t2, input logic [15:0] expv,
                                 input bit noise);
        issueStart(t0, t1, t2, expv);
        if (noise) begin
            repeat (8) @(negedge clk);
            start     = 3'b111;
            expect_tt = 16'h0000;
            @(negedge clk);
            start     = 3'b000;
        end
        waitDone();
    endtask

    function automatic logic [15:0] pickTable(input logic [15:0] expv);
        case ($urandom_range(0, 2))
            0:       return expv;
            1:       return expv ^ (16'd1 << $urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] ev;
        rst_n     = 1'b0;
        start     = 3'b000;
        expect_tt = 16'h0000;
        for (int g = 0; g < 3; g++) dev_tt[g] = 16'h0000;
        #12;
        checkReset();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] golden sweep");
        applyStimulus(16'hFA7A, 16'hFA7A, 16'hFA7A, 16'hFA7A, 1'b0);
        // waitDone returns in the slowest sweeper's FIN cycle; a start there is ignored.
        start = 3'b100;
        @(negedge clk);
        start = 3'b000;

        $display("[TB] stuck-at sweeps");
        applyStimulus(16'h0000, 16'h0000, 16'h0000, 16'hFA7A, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFA7A, 1'b0);

        $display("[TB] mid-sweep start and expect_tt changes");
        applyStimulus(16'hFA7A, 16'hFA7A, 16'hFA7A, 16'hFA7A, 1'b1);

        $display("[TB] random sweeps");
        for (int n = 0; n < 8; n++) begin
            ev = 16'($urandom);
            applyStimulus(pickTable(ev), pickTable(ev), pickTable(ev), ev, n[0]);
        end

        $display("[TB] reset mid-sweep");
        issueStart(16'h1234, 16'h5678, 16'h9ABC, 16'hFA7A);
        repeat (14) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset();
        for (int g = 0; g < 3; g++) scoreQ[g].delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] clean sweep after reset");
        applyStimulus(16'hFA7A, 16'hFA7A, 16'hFA7A, 16'hFA7A, 1'b0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
